// File: rtl/seven_seg_scan_ctrl.sv
// Binary-to-BCD converter (double dabble) feeding a multiplexed seven-segment display
// with leading-zero blanking, overflow dashes and per-digit decimal points.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BIN_W        = 14,
  parameter int unsigned REFRESH_BITS = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp
);

  // Decimal digits needed to hold the largest BIN_W-bit value.
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int unsigned BIN_DIGITS = dec_digits(BIN_W);
  localparam int unsigned BCD_N      = (BIN_DIGITS > NUM_DIGITS) ? BIN_DIGITS : NUM_DIGITS;
  localparam int unsigned BCD_W      = 4 * BCD_N;
  localparam int unsigned DISP_W     = 4 * NUM_DIGITS;
  localparam int unsigned STEP_W     = $clog2(BIN_W);
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t                  state, state_nxt;
  logic [BIN_W-1:0]        bin_sr;
  logic [BCD_W-1:0]        bcd, bcd_adj, bcd_shift;
  logic [STEP_W-1:0]       step_cnt;
  logic [DISP_W-1:0]       disp;
  logic                    last_step, start, commit, busy_nxt, done_nxt, ovf_c;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              cur_dig;
  logic                    dp_sel, all_zero;
  logic [6:0]              seg_c;
  logic [NUM_DIGITS-1:0]   anode_c;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  assign last_step = (step_cnt == STEP_W'(BIN_W - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONVERT;
      CONVERT: if (last_step) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; the display is loaded on the edge that enters COMMIT so it is visible during COMMIT
  always_comb begin
    start    = (state == IDLE) && load;
    commit   = (state == CONVERT) && last_step;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = commit;
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary bit
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
    ovf_c     = bcd_adj[BCD_W-1];
    for (int i = DISP_W; i < BCD_W; i++) ovf_c = ovf_c | bcd_shift[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr   <= '0;
      bcd      <= '0;
      step_cnt <= '0;
      disp     <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (start) begin
        bin_sr   <= bin_in;
        bcd      <= '0;
        step_cnt <= '0;
      end else if (state == CONVERT) begin
        bin_sr   <= {bin_sr[BIN_W-2:0], 1'b0};
        bcd      <= bcd_shift;
        step_cnt <= step_cnt + STEP_W'(1);
      end
      if (commit) begin
        disp     <= bcd_shift[DISP_W-1:0];
        overflow <= ovf_c;
      end
    end
  end

  // Free-running refresh counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
      if (&refresh_cnt) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // Current digit, its decimal point, and whether it sits inside the leading-zero run
  always_comb begin
    cur_dig  = '0;
    dp_sel   = 1'b0;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_dig = disp[i*4 +: 4];
        dp_sel  = dp_in[i];
      end
      if ((IDX_W'(i) >= idx) && (disp[i*4 +: 4] != 4'd0)) all_zero = 1'b0;
    end
    if (overflow)                             seg_c = 7'b1111110;
    else if (blank_lz && idx != '0 && all_zero) seg_c = 7'b1111111;
    else                                      seg_c = seg_enc(cur_dig);
    anode_c = ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode <= '1;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      anode <= anode_c;
      seg   <= seg_c;
      dp    <= ~dp_sel;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized self-checking bench for seven_seg_scan_ctrl (4 digits, 14-bit input, 4-clock refresh).
module tb_seven_seg_scan_ctrl;

  logic        clk, rst_n, load, blank_lz;
  logic [13:0] bin_in;
  logic [3:0]  dp_in;
  logic        busy, done, overflow, dp;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int mval     = 0;
  bit movf     = 1'b0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .BIN_W(14), .REFRESH_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bin_in(bin_in), .blank_lz(blank_lz),
    .dp_in(dp_in), .busy(busy), .done(done), .overflow(overflow),
    .anode(anode), .seg(seg), .dp(dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges since reset release; the scan position follows from this alone
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Expected {anode, seg, dp} after edge number e for a committed decimal value
  function automatic logic [11:0] exp_scan(input int e, input int val, input bit ovf,
                                           input bit blank, input logic [3:0] dpv);
    int         idx;
    int         p;
    logic [6:0] s;
    idx = ((e - 1) / 4) % 4;
    p   = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (ovf)                            s = 7'b1111110;
    else if (blank && idx > 0 && val < p) s = 7'b1111111;
    else                                s = seg_tab[(val / p) % 10];
    return {~(4'b0001 << idx), s, ~dpv[idx]};
  endfunction

  task automatic test_scan(input int n);
    logic [11:0] exp;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      exp = exp_scan(edges, mval, movf, blank_lz, dp_in);
      checks++;
      if ({anode, seg, dp} !== exp) begin
        failures++;
        $display("FAIL scan val=%0d edge=%0d: got %b_%b_%b expected %b_%b_%b", mval, edges,
                 anode, seg, dp, exp[11:8], exp[7:1], exp[0]);
      end
    end
  endtask

  // One conversion: checks busy/done timing, the held old display, and the new overflow flag
  task automatic do_load(input int v, input bit poke);
    logic [11:0] exp;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_before_load: busy=%b expected 0", busy);
    end
    bin_in = 14'(v);
    load   = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      checks++;
      if (busy !== (c <= 15)) begin
        failures++;
        $display("FAIL busy_cycle%0d val=%0d: got %b expected %b", c, v, busy, c <= 15);
      end
      checks++;
      if (done !== (c == 15)) begin
        failures++;
        $display("FAIL done_cycle%0d val=%0d: got %b expected %b", c, v, done, c == 15);
      end
      if (c == 16) begin
        mval = v;
        movf = (v >= 10000);
      end
      exp = exp_scan(edges, mval, movf, blank_lz, dp_in);
      checks++;
      if ({anode, seg, dp} !== exp) begin
        failures++;
        $display("FAIL hold_scan_cycle%0d val=%0d: got %b_%b_%b expected %b_%b_%b", c, mval,
                 anode, seg, dp, exp[11:8], exp[7:1], exp[0]);
      end
      if (poke && c == 5) begin
        load   = 1'b1;
        bin_in = ~14'(v);
      end
      if (c == 6) load = 1'b0;
    end
    checks++;
    if (overflow !== movf) begin
      failures++;
      $display("FAIL overflow val=%0d: got %b expected %b", v, overflow, movf);
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overflow, anode, seg, dp} !== {3'b000, 4'b1111, 7'b1111111, 1'b1}) begin
      failures++;
      $display("FAIL reset_async: got %b expected 000_1111_1111111_1",
               {busy, done, overflow, anode, seg, dp});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, overflow, anode, seg, dp} !== {3'b000, 4'b1111, 7'b1111111, 1'b1}) begin
      failures++;
      $display("FAIL reset_held: got %b expected 000_1111_1111111_1",
               {busy, done, overflow, anode, seg, dp});
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_scan(8);
  endtask

  task automatic test_basic();
    blank_lz = 1'b0;
    dp_in    = 4'b0000;
    do_load(1234, 1'b1);
    test_scan(16);
  endtask

  task automatic test_overflow();
    blank_lz = 1'b0;
    do_load(9999, 1'b0);
    test_scan(16);
    do_load(10000, 1'b0);
    test_scan(16);
    do_load(16383, 1'b0);
    test_scan(16);
    do_load(5, 1'b0);
    test_scan(16);
  endtask

  task automatic test_blanking();
    @(negedge clk);
    blank_lz = 1'b1;
    do_load(7, 1'b0);
    test_scan(16);
    do_load(0, 1'b0);
    test_scan(16);
    do_load(12000, 1'b0);
    test_scan(16);
    do_load(305, 1'b0);
    test_scan(16);
    @(negedge clk);
    blank_lz = 1'b0;
  endtask

  task automatic test_dp();
    @(negedge clk);
    dp_in = 4'b0100;
    do_load(3141, 1'b0);
    test_scan(16);
    @(negedge clk);
    dp_in = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    int          w;
    do_load(42, 1'b0);
    repeat (2) @(negedge clk);
    bin_in = 14'd42;
    load   = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      checks++;
      if (done !== (c == 15 || c == 31)) begin
        failures++;
        $display("FAIL b2b_done_cycle%0d: got %b expected %b", c, done, c == 15 || c == 31);
      end
      exp = exp_scan(edges, 42, 1'b0, blank_lz, dp_in);
      checks++;
      if ({anode, seg, dp} !== exp) begin
        failures++;
        $display("FAIL b2b_scan_cycle%0d: got %b_%b_%b expected %b_%b_%b", c,
                 anode, seg, dp, exp[11:8], exp[7:1], exp[0]);
      end
    end
    @(negedge clk);
    load = 1'b0;
    w = 0;
    while (busy === 1'b1 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: busy=%b expected 0 within 40 cycles", busy);
    end
  endtask

  task automatic test_random();
    int v;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v        = (k % 3 == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 16383));
      blank_lz = 1'($urandom);
      dp_in    = 4'($urandom);
      do_load(v, 1'($urandom));
      test_scan(16);
    end
    @(negedge clk);
    blank_lz = 1'b0;
    dp_in    = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    do_load(9876, 1'b0);
    repeat (2) @(negedge clk);
    bin_in = 14'd4321;
    load   = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overflow, anode, seg, dp} !== {3'b000, 4'b1111, 7'b1111111, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_async: got %b expected 000_1111_1111111_1",
               {busy, done, overflow, anode, seg, dp});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mval  = 0;
    movf  = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_abort_cycle%0d: done=%b busy=%b expected 0 0", c, done, busy);
      end
      exp = exp_scan(edges, 0, 1'b0, blank_lz, dp_in);
      checks++;
      if ({anode, seg, dp} !== exp) begin
        failures++;
        $display("FAIL reset_mid_scan_cycle%0d: got %b_%b_%b expected %b_%b_%b", c,
                 anode, seg, dp, exp[11:8], exp[7:1], exp[0]);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    load     = 1'b0;
    bin_in   = '0;
    blank_lz = 1'b0;
    dp_in    = 4'b0000;
    test_reset();
    test_basic();
    test_overflow();
    test_blanking();
    test_dp();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
